arb_rr_lock_n: RTL and testbench

//  N-way request/acknowledge arbiter with a selectable mode: fixed priority or round robin.
//  - Sits between N local requesters and one downstream port that may stall.
//  - The winner is registered and locked until it drops its request.
//  - An optional hold limit forces release so other requesters are not starved.
//  - Replaces the unregistered 3-way fixed-priority arbiter in new datapaths.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_pick.sv | 29 ++
 rtl/arb_rr_lock_n.sv | 111 +++++++++++
 tb/tb_arb_rr_lock_n.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the request/acknowledge lock arbiter.
package arb_pkg;

  // Lock state: IDLE while choosing the next owner, BUSY while one is locked in.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Arbitration mode as seen on mode_rr_i.
  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first set request at or above base, wrapping
// past N-1 back to 0. A base of 0 gives plain lowest-index-wins priority.
module arb_pick #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] base,
  output logic           found,
  output logic [IDW-1:0] winner
);

  // Scan N positions starting at base; the first hit wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(base) + i) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_rr_lock_n.sv
// N-way request/acknowledge arbiter with a registered, locked owner.
// Fixed priority (index 0 highest) or round robin, chosen at each pick.
// The owner keeps the lock until it drops its request, or until it has had
// MAX_HOLD acknowledged cycles while someone else is waiting.
module arb_rr_lock_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1,
  parameter int MAX_HOLD = 16,
  parameter int HCW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           mode_rr_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   ack_i,
  output logic           req_o,
  input  logic           ack_o,
  output logic [IDW-1:0] owner_o,
  output logic           busy_o
);

  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e     state_q;
  logic           mode_q;     // mode captured at the pick that started this lock
  logic [IDW-1:0] ptr_q;      // round-robin search start
  logic [HCW-1:0] hold_q;     // acknowledged cycles of the current lock

  logic [IDW-1:0] pick_base;
  logic [IDW-1:0] pick_winner;
  logic           pick_found;

  logic [N-1:0]   owner_oh;
  logic           owner_req;
  logic           others_req;
  logic           force_rel;
  logic           release_lock;

  // Fixed priority always searches from index 0.
  assign pick_base = (mode_rr_i == ARB_MODE_RR) ? ptr_q : '0;

  arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req_i),
    .base   (pick_base),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign busy_o = (state_q == ARB_BUSY);

  // Owner decode, release conditions and the downstream-facing handshake.
  always_comb begin
    owner_oh           = '0;
    owner_oh[owner_o]  = 1'b1;
    owner_req          = req_i[owner_o];
    others_req         = |(req_i & ~owner_oh);
    force_rel          = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && ack_o && others_req;
    release_lock       = !owner_req || force_rel;
    if (state_q == ARB_BUSY) begin
      req_o = owner_req;
      // A downstream stall withholds the acknowledge but keeps the lock.
      ack_i = owner_oh & {N{ack_o}};
    end else begin
      req_o = |req_i;
      ack_i = '0;
    end
  end

  // Lock state machine: pick in IDLE, count and release in BUSY.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      owner_o <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      mode_q  <= ARB_MODE_FIXED;
    end else begin
      // NOTE: non-blocking assignments, so every register here updates from the values seen before the edge.
      case (state_q)
        ARB_IDLE: begin
          if (pick_found && ack_o) begin
            state_q <= ARB_BUSY;
            owner_o <= pick_winner;
            hold_q  <= '0;
            mode_q  <= mode_rr_i;
          end
        end
        ARB_BUSY: begin
          if (release_lock) begin
            state_q <= ARB_IDLE;
            // Released owner becomes lowest priority for the next RR pick.
            if (mode_q == ARB_MODE_RR) begin
              ptr_q <= (owner_o == LAST_IDX) ? '0 : owner_o + 1'b1;
            end
          end else if (ack_o && (hold_q != HOLD_MAX)) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_lock_n.sv
// Self-checking bench for arb_rr_lock_n (N=4, MAX_HOLD=4): directed scenarios
// plus randomized traffic against a rule-level reference model.
module tb_arb_rr_lock_n;
  import arb_pkg::*;

  localparam int N          = 4;
  localparam int IDW        = 2;
  localparam int MAX_HOLD   = 4;
  localparam int WAIT_BOUND = (N - 1) * (MAX_HOLD + 1) + N;

  logic           clk = 1'b0;
  logic           rstn;
  logic           mode_rr_i;
  logic [N-1:0]   req_i;
  logic [N-1:0]   ack_i;
  logic           req_o;
  logic           ack_o;
  logic [IDW-1:0] owner_o;
  logic           busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_mode;
  int m_wait [N];

  always #5 clk = ~clk;

  arb_rr_lock_n #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mode_rr_i (mode_rr_i),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .req_o     (req_o),
    .ack_o     (ack_o),
    .owner_o   (owner_o),
    .busy_o    (busy_o)
  );

  function automatic int model_pick(input logic [N-1:0] r, input int base);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0; m_mode = 1'b0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  // Apply the arbitration rules for one clock edge with the current inputs.
  task automatic model_step();
    logic [N-1:0] own_mask;
    bit           others;
    for (int i = 0; i < N; i++)
      if (req_i[i] && ack_o && !(m_busy && m_owner == i)) m_wait[i]++;
    if (!m_busy) begin
      if (req_i != '0 && ack_o) begin
        m_owner = model_pick(req_i, (mode_rr_i == ARB_MODE_RR) ? m_ptr : 0);
        m_busy  = 1'b1;
        m_hold  = 0;
        m_mode  = mode_rr_i;
        m_wait[m_owner] = 0;
      end
    end else begin
      own_mask = '0;
      own_mask[m_owner] = 1'b1;
      others = ((req_i & ~own_mask) != '0);
      if (!req_i[m_owner] || (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1 && ack_o && others)) begin
        m_busy = 1'b0;
        if (m_mode == ARB_MODE_RR) m_ptr = (m_owner + 1) % N;
      end else if (ack_o && m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] e;
    e = '0;
    if (m_busy && ack_o) e[m_owner] = 1'b1;
    return e;
  endfunction

  function automatic logic exp_req();
    return m_busy ? req_i[m_owner] : |req_i;
  endfunction

  // Advance one clock edge; leaves time at posedge+1.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req_i = '0; ack_o = 1'b0; mode_rr_i = ARB_MODE_FIXED;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_i = 4'b0101; ack_o = 1'b1; mode_rr_i = ARB_MODE_RR;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_cmp++; if (ack_i !== 4'b0000) begin n_bad++; $display("FAIL reset_ack_i: got %b expected 0000", ack_i); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d expected 0", owner_o); end
    n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL reset_req_o_active: got %b expected 1", req_o); end
    req_i = '0; #1;
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req_o_quiet: got %b expected 0", req_o); end
    @(negedge clk); rstn = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0 || ack_i !== 4'b0000) begin n_bad++; $display("FAIL no_req_idle: got busy=%b ack_i=%b expected busy=0 ack_i=0000", busy_o, ack_i); end
    tick();
  endtask

  task automatic test_fixed();
    mode_rr_i = ARB_MODE_FIXED; req_i = 4'b0110; ack_o = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0 || req_o !== 1'b1) begin n_bad++; $display("FAIL stall_idle_no_pick: got busy=%b req_o=%b expected busy=0 req_o=1", busy_o, req_o); end
    ack_o = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b1 || owner_o !== 2'd1) begin n_bad++; $display("FAIL fixed_owner1: got busy=%b owner=%0d expected busy=1 owner=1", busy_o, owner_o); end
    n_cmp++; if (ack_i !== 4'b0010) begin n_bad++; $display("FAIL fixed_ack1: got %b expected 0010", ack_i); end
    req_i = 4'b0100;
    tick();
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0 || ack_i !== 4'b0000 || req_o !== 1'b1) begin n_bad++; $display("FAIL fixed_release: got busy=%b ack_i=%b req_o=%b expected 0 0000 1", busy_o, ack_i, req_o); end
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd2 || ack_i !== 4'b0100) begin n_bad++; $display("FAIL fixed_owner2: got owner=%0d ack_i=%b expected 2 0100", owner_o, ack_i); end
    req_i = '0;
    tick();
  endtask

  task automatic test_rr_rotation();
    do_reset();
    mode_rr_i = ARB_MODE_RR; ack_o = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_i = 4'b1111;
      tick();
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b1 || owner_o !== IDW'(k % N)) begin n_bad++; $display("FAIL rr_turn%0d: got busy=%b owner=%0d expected busy=1 owner=%0d", k, busy_o, owner_o, k % N); end
      tick();
      tick();
      req_i = 4'b1111 & ~(4'b0001 << (k % N));
      tick();
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    mode_rr_i = ARB_MODE_FIXED; ack_o = 1'b1; req_i = 4'b0100;
    tick();
    tick();
    req_i = 4'b0101; ack_o = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_cmp++; if (ack_i !== 4'b0000 || busy_o !== 1'b1 || owner_o !== 2'd2) begin n_bad++; $display("FAIL stall_cycle%0d: got ack_i=%b busy=%b owner=%0d expected 0000 1 2", s, ack_i, busy_o, owner_o); end
      tick();
    end
    ack_o = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack_i !== 4'b0100) begin n_bad++; $display("FAIL stall_resume_ack: got %b expected 0100", ack_i); end
    for (int e = 1; e <= 3; e++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (busy_o !== (e < 3)) begin n_bad++; $display("FAIL stall_hold_frozen_e%0d: got busy=%b expected %b", e, busy_o, (e < 3)); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL stall_next_owner: got owner=%0d busy=%b expected 0 1", owner_o, busy_o); end
    req_i = '0;
    tick();
  endtask

  task automatic test_forced_release();
    do_reset();
    mode_rr_i = ARB_MODE_RR; ack_o = 1'b1; req_i = 4'b1001;
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd0 || ack_i !== 4'b0001) begin n_bad++; $display("FAIL force_first_owner: got owner=%0d ack_i=%b expected 0 0001", owner_o, ack_i); end
    for (int e = 1; e <= 4; e++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (busy_o !== (e < 4)) begin n_bad++; $display("FAIL force_edge%0d: got busy=%b expected %b", e, busy_o, (e < 4)); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd3 || ack_i !== 4'b1000) begin n_bad++; $display("FAIL force_next_owner: got owner=%0d ack_i=%b expected 3 1000", owner_o, ack_i); end
    req_i = 4'b0001;
    tick();
    req_i = 4'b0011;
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL force_ptr_wrap: got owner=%0d expected 0", owner_o); end
    req_i = '0;
    tick();
    req_i = 4'b0100;
    tick();
    for (int e = 0; e < 6; e++) tick();
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b1 || owner_o !== 2'd2) begin n_bad++; $display("FAIL sole_no_force: got busy=%b owner=%0d expected 1 2", busy_o, owner_o); end
    req_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    mode_rr_i = ARB_MODE_RR; ack_o = 1'b1; req_i = 4'b0100;
    tick();
    req_i = '0;
    tick();
    req_i = 4'b1010;
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd3) begin n_bad++; $display("FAIL midrst_setup_owner: got %0d expected 3", owner_o); end
    tick();
    rstn = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (busy_o !== 1'b0 || ack_i !== 4'b0000 || owner_o !== 2'd0) begin n_bad++; $display("FAIL midrst_immediate: got busy=%b ack_i=%b owner=%0d expected 0 0000 0", busy_o, ack_i, owner_o); end
    req_i = '0;
    @(negedge clk); rstn = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (ack_i !== 4'b0000 || busy_o !== 1'b0) begin n_bad++; $display("FAIL midrst_no_partial_ack: got ack_i=%b busy=%b expected 0000 0", ack_i, busy_o); end
    req_i = 4'b1111;
    tick();
    @(negedge clk);
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL midrst_rr_from_0: got %0d expected 0", owner_o); end
    req_i = '0;
    tick();
  endtask

  task automatic test_random(input bit rr_only, input int cycles);
    int max_wait;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      mode_rr_i = rr_only ? ARB_MODE_RR : 1'($urandom_range(0, 1));
      ack_o     = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) begin
          if (m_busy && m_owner == i && (m_hold >= MAX_HOLD || $urandom_range(0, 3) == 0)) req_i[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_i[i] = 1'b1;
        end
      end
      @(negedge clk);
      n_cmp++; if (!$onehot0(ack_i)) begin n_bad++; $display("FAIL rand_onehot c%0d: got ack_i=%b expected one-hot or zero", c, ack_i); end
      n_cmp++; if (ack_i !== exp_ack()) begin n_bad++; $display("FAIL rand_ack c%0d: got %b expected %b", c, ack_i, exp_ack()); end
      n_cmp++; if (busy_o !== m_busy) begin n_bad++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy_o, m_busy); end
      n_cmp++; if (req_o !== exp_req()) begin n_bad++; $display("FAIL rand_req_o c%0d: got %b expected %b", c, req_o, exp_req()); end
      if (m_busy) begin
        n_cmp++; if (owner_o !== IDW'(m_owner)) begin n_bad++; $display("FAIL rand_owner c%0d: got %0d expected %0d", c, owner_o, m_owner); end
      end
      if (rr_only) begin
        max_wait = 0;
        for (int i = 0; i < N; i++) if (m_wait[i] > max_wait) max_wait = m_wait[i];
        n_cmp++; if (max_wait > WAIT_BOUND) begin n_bad++; $display("FAIL rand_starve c%0d: got wait=%0d expected <= %0d", c, max_wait, WAIT_BOUND); end
      end
      tick();
    end
    req_i = '0;
    tick();
  endtask

  initial begin
    rstn = 1'b0; req_i = '0; ack_o = 1'b0; mode_rr_i = ARB_MODE_FIXED;
    model_reset();
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_stall();
    test_forced_release();
    test_reset_mid_busy();
    test_random(1'b0, 4000);
    test_random(1'b1, 6000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
